// File: rtl/vx_dma_arbiter.sv
// Round-robin arbiter sharing one DMA engine among NUM_REQS requesters, one transfer in flight.
// Optional VX_DMA_ARB_PERF_EN adds perf_grants / perf_stalls counters and their ports.
module vx_dma_arbiter #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_src,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_dst,
  input  logic [NUM_REQS*SIZE_WIDTH-1:0] req_size,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           eng_valid,
  output logic [ADDR_WIDTH-1:0]          eng_src,
  output logic [ADDR_WIDTH-1:0]          eng_dst,
  output logic [SIZE_WIDTH-1:0]          eng_size,
  input  logic                           eng_ready,
  input  logic                           eng_done,
  output logic [NUM_REQS-1:0]            rsp_valid,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  output logic                           busy,
`ifdef VX_DMA_ARB_PERF_EN
  output logic [31:0]                    perf_grants,
  output logic [31:0]                    perf_stalls,
`endif
  output logic                           err
);

  localparam int REQ_SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]              state;
  logic [REQ_SEL_BITS-1:0] rr_ptr;
  logic [REQ_SEL_BITS-1:0] winner;
  logic [REQ_SEL_BITS-1:0] owner;
  logic                    found;
  logic                    accept;
  int unsigned             idx;
  logic [ADDR_WIDTH-1:0]   src_q;
  logic [ADDR_WIDTH-1:0]   dst_q;
  logic [SIZE_WIDTH-1:0]   size_q;
  logic [TAG_WIDTH-1:0]    tag_q;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQS;
      if (!found && req_valid[idx[REQ_SEL_BITS-1:0]]) begin
        found  = 1'b1;
        winner = idx[REQ_SEL_BITS-1:0];
      end
    end
  end

  assign accept = (state == IDLE) && found;

  // Gated by reset so every output reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset && accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  assign rsp_tag   = (state == RESP) ? tag_q : '0;
  assign eng_valid = (state == ISSUE);
  assign eng_src   = src_q;
  assign eng_dst   = dst_q;
  assign eng_size  = size_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      size_q <= '0;
      tag_q  <= '0;
      err    <= 1'b0;
    end else begin
      // Done outside WAIT (including alongside eng_ready in ISSUE) is an early/stray pulse.
      if (eng_done && state != WAIT) err <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            src_q  <= req_src[winner*ADDR_WIDTH +: ADDR_WIDTH];
            dst_q  <= req_dst[winner*ADDR_WIDTH +: ADDR_WIDTH];
            size_q <= req_size[winner*SIZE_WIDTH +: SIZE_WIDTH];
            tag_q  <= req_tag[winner*TAG_WIDTH +: TAG_WIDTH];
            owner  <= winner;
            rr_ptr <= (32'(winner) == NUM_REQS - 1) ? '0 : winner + 1'b1;
            state  <= (req_size[winner*SIZE_WIDTH +: SIZE_WIDTH] == '0) ? RESP : ISSUE;
          end
        end
        ISSUE:   if (eng_ready) state <= WAIT;
        WAIT:    if (eng_done) state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VX_DMA_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (accept) perf_grants <= perf_grants + 32'd1;
      if ((|req_valid) && state != IDLE) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
